// File: rtl/appx_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : appx_dot_accum
// Brief    : Saturating accumulator that sums LEN unsigned 32-bit products
//            from the approximate multiplier into one dot-product result.
// Revision : 1.0 - initial release
// ============================================================================
module appx_dot_accum #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] c_acc_max = {ACC_W{1'b1}};
    localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;

    logic             w_beat;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;

    // One extra bit catches the carry-out that triggers saturation.
    assign w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - 32){1'b0}}, prod};
    assign w_carry = w_sum[ACC_W];
    assign w_beat  = (r_state == S_ACCUM) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_nxt = '0;
                    w_ovf_nxt = 1'b0;
                    w_cnt_nxt = len;
                    // An empty vector skips accumulation and reports zero.
                    w_state_nxt = (len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_beat) begin
                    if (w_carry) begin
                        w_acc_nxt = c_acc_max;
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_acc_nxt = w_sum[ACC_W-1:0];
                    end
                    w_cnt_nxt = r_cnt - c_len_one;
                    if (r_cnt == c_len_one) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake outputs come straight from the state register.
    assign in_ready  = (r_state == S_ACCUM);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign acc_out   = r_acc;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_appx_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_appx_dot_accum
// Brief    : Scoreboard bench for appx_dot_accum with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_appx_dot_accum;

    localparam int ACC_W = 33;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic             ovf;
    } exp_t;

    exp_t sb[$];

    appx_dot_accum #(
        .ACC_W(ACC_W),
        .LEN_W(LEN_W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .prod     (prod),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .acc_out  (acc_out),
        .ovf      (ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every output handshake and holds-stable during stalls.
    logic             m_prev_stall = 1'b0;
    logic [ACC_W-1:0] m_prev_acc   = '0;
    logic             m_prev_ovf   = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev_stall = 1'b0;
        end else begin
            if (out_valid && m_prev_stall) begin
                chk("stall_acc_stable", 64'(acc_out), 64'(m_prev_acc));
                chk("stall_ovf_stable", 64'(ovf), 64'(m_prev_ovf));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got acc 0x%0h, expected no result", acc_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result_acc", 64'(acc_out), 64'(e.acc));
                    chk("result_ovf", 64'(ovf), 64'(e.ovf));
                end
            end
            m_prev_stall = out_valid && !out_ready;
            m_prev_acc   = acc_out;
            m_prev_ovf   = ovf;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ACC_W-1:0] a, input logic o);
        exp_t e;
        e.acc = a;
        e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic send(input logic [31:0] p);
        int n;
        n        = 0;
        in_valid = 1'b1;
        prod     = p;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0, required 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic collect(input int stall);
        int n;
        n = 0;
        out_ready = 1'b0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout: got out_valid 0, required 1");
        end
        for (int i = 0; i < stall; i++) begin
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        logic [6:0] pat;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        prod      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acc", 64'(acc_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1. Basic back-to-back vector
        push(33'h1000C, 1'b0);
        do_start(8'd3);
        chk("t1_busy", 64'(busy), 64'd1);
        send(32'd4);
        send(32'd8);
        send(32'h10000);
        @(negedge clk);
        chk("t1_latency_out_valid", 64'(out_valid), 64'd1);
        collect(0);

        // 2. Input gaps and output backpressure
        push(33'd20, 1'b0);
        do_start(8'd4);
        pat   = 7'b1011001;
        beats = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            prod     = 32'd5;
            @(negedge clk);
            if (in_valid && in_ready) beats++;
            tick();
        end
        in_valid = 1'b0;
        chk("t2_beats", 64'(beats), 64'd4);
        collect(5);

        // 3. Empty vector
        push(33'd0, 1'b0);
        do_start(8'd0);
        @(negedge clk);
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        collect(0);

        // 4. Saturation, then recovery on the next vector
        push(33'h1_FFFF_FFFF, 1'b1);
        do_start(8'd3);
        repeat (3) send(32'hFFFF_0000);
        collect(2);
        push(33'd7, 1'b0);
        do_start(8'd1);
        send(32'd7);
        collect(0);

        // 5. start ignored in ACCUM and in DONE
        push(33'd3, 1'b0);
        do_start(8'd2);
        start = 1'b1;
        len   = 8'd0;
        send(32'd1);
        start = 1'b0;
        send(32'd2);
        @(negedge clk);
        chk("t5_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        start     = 1'b1;
        len       = 8'd3;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        len       = '0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t5_idle_busy", 64'(busy), 64'd0);
        tick();
        @(negedge clk);
        chk("t5_no_restart", 64'(busy), 64'd0);

        // 6. Reset mid-vector
        tick();
        do_start(8'd5);
        send(32'd100);
        send(32'd200);
        rst_n = 1'b0;
        #1;
        chk("t6_acc", 64'(acc_out), 64'd0);
        chk("t6_ovf", 64'(ovf), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        push(33'd9, 1'b0);
        do_start(8'd1);
        send(32'd9);
        collect(0);

        repeat (3) tick();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
